worker_ctrl: RTL and testbench

Sequencer for the graph-partition worker datapath. For each batch of Q vertex IDs it:
- fetches the batch's vid word and latches the Q vertex IDs;
- streams the Q×NUM_SUB adjacency (dist) and partition-location (loc) reads;
- issues the accumulate, first and last strobes the datapath uses to build per-partition neighbour counts and pick the argmax;
- issues the per-batch write of the resulting next-partition word.

It sits between the top-level start/done handshake and the worker datapath plus its vid/dist/loc/next SRAMs.

---
 rtl/worker_pkg.sv | 40 ++++
 rtl/worker_fetch_cnt.sv | 75 +++++++
 rtl/worker_ctrl.sv | 150 +++++++++++++++
 tb/tb_worker_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/worker_pkg.sv
// worker_pkg: shared definitions for the graph-partition worker sequencer.
// Holds the datapath geometry, the derived counter widths, the sequencer
// state encoding and the dist SRAM address builder.
package worker_pkg;

  localparam int Q               = 16;  // vertex IDs per vid word
  localparam int NUM_SUB         = 16;  // sub-batches per vertex
  localparam int VID_BW          = 16;  // bits per vertex ID
  localparam int VID_ADDR_SPACE  = 4;
  localparam int DIST_ADDR_SPACE = 16;
  localparam int LOC_ADDR_SPACE  = 4;
  localparam int NEXT_ADDR_SPACE = 4;
  localparam int PIPE_LAT        = 2;   // acc_last to argmax valid

  localparam int Q_W         = $clog2(Q);
  localparam int S_W         = $clog2(NUM_SUB);
  // Low vertex-ID bits that fit in the dist address above the s field.
  localparam int VID_FIELD_W = DIST_ADDR_SPACE - S_W;
  localparam int DRAIN_W     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    VID_RD,
    VID_WAIT,
    VID_CAP,
    FETCH,
    DRAIN,
    WB,
    DONE
  } worker_state_e;

  // dist address = {truncated vertex ID, sub-batch index}.
  function automatic logic [DIST_ADDR_SPACE-1:0] dist_addr(
    input logic [VID_BW-1:0] vid,
    input logic [S_W-1:0]    s
  );
    return {vid[VID_FIELD_W-1:0], s};
  endfunction

endpackage

// File: rtl/worker_fetch_cnt.sv
// worker_fetch_cnt: nested vertex-slot (q, outer) / sub-batch (s, inner)
// counter for the FETCH phase, plus the strobe pipeline that turns the
// issued (q, s) into accumulate strobes one cycle after the address.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   clr                 hold q/s at zero (outside FETCH)
//   step                advance q/s by one; one address is issued this cycle
//   q, s                current counter values (address being formed)
//   last                q and s both at their final value
//   acc_en/first/last   delayed issue valid, s==0, s==NUM_SUB-1
//   acc_slot            delayed q for the data currently returning
module worker_fetch_cnt
  import worker_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           step,
  output logic [Q_W-1:0] q,
  output logic [S_W-1:0] s,
  output logic           last,
  output logic           acc_en,
  output logic           acc_first,
  output logic           acc_last,
  output logic [Q_W-1:0] acc_slot
);

  logic           s_wrap;
  // Issue stage: aligned with the registered dist/loc address in the top.
  logic           iss_valid;
  logic [Q_W-1:0] iss_q;
  logic [S_W-1:0] iss_s;

  assign s_wrap = (s == S_W'(NUM_SUB - 1));
  assign last   = s_wrap && (q == Q_W'(Q - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      q <= '0;
      s <= '0;
    end else if (step) begin
      if (s_wrap) begin
        s <= '0;
        q <= q + Q_W'(1);
      end else begin
        s <= s + S_W'(1);
      end
    end
  end

  // Not cleared by clr: the tail of the pipeline drains after FETCH ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      iss_q     <= '0;
      iss_s     <= '0;
      acc_en    <= 1'b0;
      acc_first <= 1'b0;
      acc_last  <= 1'b0;
      acc_slot  <= '0;
    end else begin
      iss_valid <= step;
      if (step) begin
        iss_q <= q;
        iss_s <= s;
      end
      acc_en    <= iss_valid;
      acc_first <= iss_valid && (iss_s == '0);
      acc_last  <= iss_valid && (iss_s == S_W'(NUM_SUB - 1));
      if (iss_valid) acc_slot <= iss_q;
    end
  end

endmodule

// File: rtl/worker_ctrl.sv
// worker_ctrl: per-batch sequencer for the graph-partition worker.
// For each batch: read the vid word, latch Q vertex IDs, stream Q*NUM_SUB
// dist/loc reads with accumulate strobes, wait PIPE_LAT for the argmax,
// then write the next-partition word at the batch index.
//
// Handshake: start is a one-cycle pulse honoured only in IDLE (num_batch is
// captured with it); busy is high from the cycle after start until done;
// done is a one-cycle pulse that coincides with busy falling.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start, num_batch           run request and batch count (0..16)
//   vid_rdata / vid_raddr      vid SRAM (slot 0 in the MSBs)
//   dist_raddr, loc_raddr      adjacency / partition-location SRAM addresses
//   acc_en/first/last/slot     datapath accumulate strobes
//   next_wen, next_waddr       next-partition SRAM write
//   busy, done                 run status
//   dbg_state                  current sequencer state
// All outputs are registered; SRAM read latency is one cycle.
module worker_ctrl
  import worker_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [VID_ADDR_SPACE:0]    num_batch,
  input  logic [Q*VID_BW-1:0]        vid_rdata,
  output logic [VID_ADDR_SPACE-1:0]  vid_raddr,
  output logic [DIST_ADDR_SPACE-1:0] dist_raddr,
  output logic [LOC_ADDR_SPACE-1:0]  loc_raddr,
  output logic                       acc_en,
  output logic                       acc_first,
  output logic                       acc_last,
  output logic [Q_W-1:0]             acc_slot,
  output logic                       next_wen,
  output logic [NEXT_ADDR_SPACE-1:0] next_waddr,
  output logic                       busy,
  output logic                       done,
  output worker_state_e              dbg_state
);

  worker_state_e             state, next_state;
  logic [VID_ADDR_SPACE:0]   nb_q;
  logic [VID_ADDR_SPACE-1:0] b;
  logic [VID_BW-1:0]         vid_q [Q];
  logic [DRAIN_W-1:0]        drain_cnt;
  // An empty run spends one extra cycle in DONE so done lands two cycles
  // after start.
  logic                      zero_wait;
  logic                      last_batch;

  logic [Q_W-1:0]            q;
  logic [S_W-1:0]            s;
  logic                      fetch_last;
  logic                      fetch_step;

  assign dbg_state  = state;
  assign fetch_step = (state == FETCH);
  assign last_batch = ({1'b0, b} == (nb_q - 1'b1));

  worker_fetch_cnt u_fetch_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (!fetch_step),
    .step      (fetch_step),
    .q         (q),
    .s         (s),
    .last      (fetch_last),
    .acc_en    (acc_en),
    .acc_first (acc_first),
    .acc_last  (acc_last),
    .acc_slot  (acc_slot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = (num_batch == '0) ? DONE : VID_RD;
      VID_RD:   next_state = VID_WAIT;
      VID_WAIT: next_state = VID_CAP;
      VID_CAP:  next_state = FETCH;
      FETCH:    if (fetch_last) next_state = DRAIN;
      DRAIN:    if (drain_cnt == DRAIN_W'(PIPE_LAT - 1)) next_state = WB;
      WB:       next_state = last_batch ? DONE : VID_RD;
      DONE:     if (!zero_wait) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nb_q       <= '0;
      b          <= '0;
      drain_cnt  <= '0;
      zero_wait  <= 1'b0;
      vid_raddr  <= '0;
      dist_raddr <= '0;
      loc_raddr  <= '0;
      next_wen   <= 1'b0;
      next_waddr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < Q; i++) vid_q[i] <= '0;
    end else begin
      next_wen <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            nb_q      <= num_batch;
            b         <= '0;
            busy      <= 1'b1;
            zero_wait <= (num_batch == '0);
          end
        end
        VID_RD: vid_raddr <= b;
        VID_CAP: begin
          for (int i = 0; i < Q; i++)
            vid_q[i] <= vid_rdata[(Q-1-i)*VID_BW +: VID_BW];
        end
        FETCH: begin
          dist_raddr <= dist_addr(vid_q[q], s);
          loc_raddr  <= LOC_ADDR_SPACE'(s);
        end
        DRAIN: drain_cnt <= drain_cnt + DRAIN_W'(1);
        WB: begin
          next_wen   <= 1'b1;
          next_waddr <= NEXT_ADDR_SPACE'(b);
          drain_cnt  <= '0;
          if (!last_batch) b <= b + VID_ADDR_SPACE'(1);
        end
        DONE: begin
          if (zero_wait) begin
            zero_wait <= 1'b0;
          end else begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_worker_ctrl.sv
// Testbench for worker_ctrl: directed runs with random vid contents checked
// cycle-by-cycle against a timing model derived from batch arithmetic.
module tb_worker_ctrl;
  import worker_pkg::*;

  localparam int QS = Q * NUM_SUB;
  localparam int BP = QS + 4 + PIPE_LAT;  // batch period
  localparam int FIELD_MOD = 1 << (DIST_ADDR_SPACE - $clog2(NUM_SUB));

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                       start = 1'b0;
  logic [VID_ADDR_SPACE:0]    num_batch = '0;
  logic [Q*VID_BW-1:0]        vid_rdata = '0;
  logic [VID_ADDR_SPACE-1:0]  vid_raddr;
  logic [DIST_ADDR_SPACE-1:0] dist_raddr;
  logic [LOC_ADDR_SPACE-1:0]  loc_raddr;
  logic                       acc_en, acc_first, acc_last;
  logic [Q_W-1:0]             acc_slot;
  logic                       next_wen;
  logic [NEXT_ADDR_SPACE-1:0] next_waddr;
  logic                       busy, done;
  worker_state_e              dbg_state;

  worker_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_batch  (num_batch),
    .vid_rdata  (vid_rdata),
    .vid_raddr  (vid_raddr),
    .dist_raddr (dist_raddr),
    .loc_raddr  (loc_raddr),
    .acc_en     (acc_en),
    .acc_first  (acc_first),
    .acc_last   (acc_last),
    .acc_slot   (acc_slot),
    .next_wen   (next_wen),
    .next_waddr (next_waddr),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // vid SRAM, one-cycle read latency
  logic [Q*VID_BW-1:0] vid_mem [16];
  always @(posedge clk) vid_rdata <= vid_mem[vid_raddr];

  // scoreboard counters
  int checks = 0;
  int errors = 0;
  int cur_t  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, cur_t, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_vid_raddr"}, 32'(vid_raddr), 32'(0));
    chk({tag, "_dist_raddr"}, 32'(dist_raddr), 32'(0));
    chk({tag, "_loc_raddr"}, 32'(loc_raddr), 32'(0));
    chk({tag, "_acc_en"}, 32'(acc_en), 32'(0));
    chk({tag, "_acc_first"}, 32'(acc_first), 32'(0));
    chk({tag, "_acc_last"}, 32'(acc_last), 32'(0));
    chk({tag, "_acc_slot"}, 32'(acc_slot), 32'(0));
    chk({tag, "_next_wen"}, 32'(next_wen), 32'(0));
    chk({tag, "_next_waddr"}, 32'(next_waddr), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
  endtask

  task automatic fill_random(input int nwords);
    for (int w = 0; w < nwords; w++)
      for (int i = 0; i < Q; i++)
        vid_mem[w][(Q-1-i)*VID_BW +: VID_BW] = VID_BW'($urandom);
  endtask

  // Vertex ID held in slot q of vid word k.
  function automatic int vid_of(input int k, input int q);
    logic [Q*VID_BW-1:0] w;
    w = vid_mem[k];
    return int'(w[(Q-1-q)*VID_BW +: VID_BW]);
  endfunction

  // Start a run of n batches at edge 0, then compare every cycle against the
  // model. restart_at: edge at which start is pulsed again (-1 none).
  // abort_at: edge at which rst_n is sampled low (-1 none).
  task automatic run_and_check(input int n, input int restart_at, input int abort_at);
    int done_t, last_t, k, o, idx, exp_dist;
    logic e_en, e_first, e_last, e_wen;
    done_t = (n == 0) ? 2 : n * BP + 1;
    last_t = (abort_at >= 0) ? abort_at + 30 : done_t + 3;
    @(negedge clk);
    start = 1'b1;
    num_batch = (VID_ADDR_SPACE+1)'(n);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    num_batch = (VID_ADDR_SPACE+1)'($urandom_range(0, 16));
    for (int t = 0; t <= last_t; t++) begin
      cur_t = t;
      if (abort_at >= 0 && t == abort_at) begin
        check_all_zero("reset_mid");
      end else if (abort_at >= 0 && t > abort_at) begin
        chk("post_rst_next_wen", 32'(next_wen), 32'(0));
        chk("post_rst_done", 32'(done), 32'(0));
        chk("post_rst_busy", 32'(busy), 32'(0));
        chk("post_rst_acc_en", 32'(acc_en), 32'(0));
      end else begin
        k = t / BP;
        o = t % BP;
        e_en = 1'b0; e_first = 1'b0; e_last = 1'b0;
        if (k < n && o >= 4 && o <= 3 + QS) begin
          idx = o - 4;
          exp_dist = (vid_of(k, idx / NUM_SUB) % FIELD_MOD) * NUM_SUB + idx % NUM_SUB;
          chk("dist_raddr", 32'(dist_raddr), 32'(exp_dist));
          chk("loc_raddr", 32'(loc_raddr), 32'(idx % NUM_SUB));
        end
        if (k < n && o >= 5 && o <= 4 + QS) begin
          idx = o - 5;
          e_en = 1'b1;
          e_first = (idx % NUM_SUB == 0);
          e_last = (idx % NUM_SUB == NUM_SUB - 1);
          chk("acc_slot", 32'(acc_slot), 32'(idx / NUM_SUB));
        end
        chk("acc_en", 32'(acc_en), 32'(e_en));
        chk("acc_first", 32'(acc_first), 32'(e_first));
        chk("acc_last", 32'(acc_last), 32'(e_last));
        e_wen = (n > 0 && o == 0 && k >= 1 && k <= n);
        chk("next_wen", 32'(next_wen), 32'(e_wen));
        if (e_wen) chk("next_waddr", 32'(next_waddr), 32'(k - 1));
        if (n > 0 && k < n && o == 1) chk("vid_raddr", 32'(vid_raddr), 32'(k));
        chk("busy", 32'(busy), 32'(t < done_t));
        chk("done", 32'(done), 32'(t == done_t));
      end
      start = (t + 1 == restart_at);
      rst_n = !(t + 1 == abort_at);
      @(negedge clk);
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int w = 0; w < 16; w++) vid_mem[w] = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single batch, IDs 0x0010..0x001F
    for (int i = 0; i < Q; i++) vid_mem[0][(Q-1-i)*VID_BW +: VID_BW] = VID_BW'(16 + i);
    run_and_check(1, -1, -1);

    // three batches with random IDs
    fill_random(3);
    run_and_check(3, -1, -1);

    // empty run
    run_and_check(0, -1, -1);

    // start pulsed again mid-run is ignored
    fill_random(1);
    run_and_check(1, 100, -1);

    // reset mid-FETCH, then a normal run
    fill_random(1);
    run_and_check(1, -1, 150);
    fill_random(1);
    run_and_check(1, -1, -1);

    // vertex-ID truncation: 0xFFFF in slot 15
    fill_random(1);
    vid_mem[0][VID_BW-1:0] = 16'hFFFF;
    run_and_check(1, -1, -1);

    // random runs
    for (int r = 0; r < 2; r++) begin
      fill_random(2);
      run_and_check($urandom_range(1, 2), -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
